cu_sequencer: RTL
=================

Name: cu_sequencer

Overview:
- Program sequencer and instruction decoder for the 4-bit computational unit (CU).
- Fetches 8-bit instructions from program memory, holds them in an instruction register and decodes them into CU controls: source_sel, reg_en, i_sel, x_sel, y_sel, ir_nibble and the CU sync_reset.
- Executes conditional and unconditional two-word jumps using the CU r_eq_0 flag.
- Sits between program memory and the CU at the top level of the processor.

Parameters:
- PC_WIDTH, 8, width of program counter and pm_address; valid range 4..8; jump targets use pm_data[PC_WIDTH-1:0].

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- pm_data  in  8  program memory read data; combinational read of pm_address.
- r_eq_0  in  1  CU zero flag.
- pm_address  out  PC_WIDTH  program counter, drives program memory.
- cu_sync_reset  out  1  drives CU sync_reset.
- ir_nibble  out  4  always ir[3:0].
- source_sel  out  4  CU data_bus mux select.
- reg_en  out  9  CU register enables. Bits: 0 x0, 1 x1, 2 y0, 3 y1, 4 r, 5 m, 6 i, 7 dm write, 8 o_reg.
- i_sel  out  1  0 = i loads data_bus; 1 = i <= i+m.
- x_sel  out  1  ALU x operand select.
- y_sel  out  1  ALU y operand select.

Behaviour:
- One clock domain.
- Registers: pc, ir, and a 2-bit state: RST, FETCH, EXEC, JADDR.
- reset_n low, asynchronous: pc=0, ir=8'h00, state=RST. All decode outputs are 0; cu_sync_reset=1.
- RST: cu_sync_reset=1 for exactly one clock after reset_n rises; next state FETCH.
- FETCH: ir <= pm_data; pc <= pc+1; next state EXEC. All reg_en bits are 0.
- EXEC: decode outputs are driven from ir for exactly one cycle.
  - Jump opcodes go to JADDR; all others go to FETCH.
- JADDR: pm_data is the jump target word.
  - Jump taken: pc <= pm_data[PC_WIDTH-1:0].
  - Not taken: pc <= pc+1 (skips the target word).
  - Next state FETCH.
- Cycles per instruction: 2 for non-jump, 3 for jump.
- PC arithmetic is modulo 2^PC_WIDTH; pc wraps from all-ones to 0 silently.
- Decode in EXEC (dst/src 3-bit code: 0 x0, 1 x1, 2 y0, 3 y1, 4 o_reg, 5 m, 6 i, 7 dm):
  - Load, ir[7]=0: dst=ir[6:4]; source_sel=8 (pm_data); the immediate is ir[3:0] via ir_nibble.
  - Move, ir[7:6]=10: dst=ir[5:3], src=ir[2:0]. source_sel = src (0..7), with src code 4 mapping to source_sel 4 (r).
    - When src==dst, source_sel=9 (i_pins).
  - ALU, ir[7:5]=110: reg_en[4]=1; x_sel=ir[4]; y_sel=ir[3]; source_sel=0.
  - Unconditional jump, ir[7:4]=1110: taken.
  - Conditional jump (JNZ), ir[7:4]=1111: taken iff r_eq_0==0, sampled in the JADDR cycle.
- Destination enable for load and move: dst 0..3 sets reg_en[dst]; dst 4 sets reg_en[8]; 5 sets reg_en[5]; 6 sets reg_en[6] with i_sel=0; 7 sets reg_en[7].
- Auto-increment: when src==7 or dst==7 on a load or move, reg_en[6]=1 with i_sel=1 in the same EXEC cycle.
  - Exception: dst==6 takes priority; i loads data_bus and there is no increment.
- Outside EXEC, reg_en, x_sel, y_sel, i_sel and source_sel are all 0. These outputs are combinational from state and ir.
- reset_n asserted mid-instruction aborts it immediately: no enables and no pc update. The sequencer restarts at RST.

Test Plan:
- Reset release, pm[0]=8'h05 (load x0,5) -> one RST cycle with cu_sync_reset=1. FETCH with pm_address=0, then EXEC with reg_en=9'h001, source_sel=8, ir_nibble=5, then pm_address=1.
- Move o_reg<-x1, ir=8'hA1 -> EXEC reg_en=9'h100, source_sel=1. ir=8'hA4 (dst=src=4) -> source_sel=9.
- Move x0<-dm, ir=8'h87 -> EXEC reg_en=9'h041, source_sel=7, i_sel=1. Load i,3, ir=8'h63 -> reg_en=9'h040, i_sel=0.
- ALU ir=8'hD9 -> reg_en=9'h010, x_sel=1, y_sel=1, ir_nibble=9. Next FETCH after 2 cycles.
- JNZ at pc=4, target word pm[5]=8'h20, r_eq_0=0 -> pm_address=8'h20 after 3 cycles. Same with r_eq_0=1 -> pm_address=6.
- Run pc to 8'hFF (non-jump) -> next fetch address 8'h00. Assert reset_n low during JADDR -> pc=0, outputs 0 asynchronously.

Source files
------------

// File: rtl/cu_sequencer.sv
// Program sequencer and instruction decoder for the 4-bit computational unit.
// Fetches 8-bit instructions, decodes them into CU controls, and executes
// two-word conditional/unconditional jumps using the CU zero flag.
module cu_sequencer #(
    parameter int unsigned PC_WIDTH = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [7:0]          pm_data,
    input  logic                r_eq_0,
    output logic [PC_WIDTH-1:0] pm_address,
    output logic                cu_sync_reset,
    output logic [3:0]          ir_nibble,
    output logic [3:0]          source_sel,
    output logic [8:0]          reg_en,
    output logic                i_sel,
    output logic                x_sel,
    output logic                y_sel
);

    localparam int unsigned IR_W  = 8;
    localparam int unsigned SEL_W = 4;
    localparam int unsigned EN_W  = 9;

    localparam logic [1:0] ST_RST   = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_EXEC  = 2'd2;
    localparam logic [1:0] ST_JADDR = 2'd3;

    // Source codes that select something other than a register
    localparam logic [SEL_W-1:0] SRC_PM_DATA = 4'd8;
    localparam logic [SEL_W-1:0] SRC_I_PINS  = 4'd9;

    logic [1:0]          state;
    logic [1:0]          state_nxt;
    logic [PC_WIDTH-1:0] pc;
    logic [PC_WIDTH-1:0] pc_nxt;
    logic [IR_W-1:0]     ir;
    logic [IR_W-1:0]     ir_nxt;

    logic                is_load;
    logic                is_move;
    logic                is_alu;
    logic                is_jump;
    logic                jump_taken;
    logic [2:0]          dst;
    logic [2:0]          src;

    // Instruction class and operand field extraction
    always_comb begin
        is_load    = ~ir[7];
        is_move    = (ir[7:6] == 2'b10);
        is_alu     = (ir[7:5] == 3'b110);
        is_jump    = (ir[7:5] == 3'b111);
        dst        = ir[7] ? ir[5:3] : ir[6:4];
        src        = ir[2:0];
        jump_taken = ir[4] ? ~r_eq_0 : 1'b1;
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_RST;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_RST:   state_nxt = ST_FETCH;
            ST_FETCH: state_nxt = ST_EXEC;
            ST_EXEC:  state_nxt = is_jump ? ST_JADDR : ST_FETCH;
            ST_JADDR: state_nxt = ST_FETCH;
            default:  state_nxt = ST_RST;
        endcase
    end

    // Program counter and instruction register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc <= '0;
            ir <= '0;
        end else begin
            pc <= pc_nxt;
            ir <= ir_nxt;
        end
    end

    // PC / IR update: fetch increments, jump-address word either loads or is skipped
    always_comb begin
        pc_nxt = pc;
        ir_nxt = ir;
        case (state)
            ST_FETCH: begin
                ir_nxt = pm_data;
                pc_nxt = pc + PC_WIDTH'(1);
            end
            ST_JADDR: begin
                pc_nxt = jump_taken ? pm_data[PC_WIDTH-1:0] : pc + PC_WIDTH'(1);
            end
            default: begin
                pc_nxt = pc;
            end
        endcase
    end

    // CU control decode, active only during EXEC
    always_comb begin
        reg_en     = EN_W'(0);
        source_sel = SEL_W'(0);
        i_sel      = 1'b0;
        x_sel      = 1'b0;
        y_sel      = 1'b0;
        if (state == ST_EXEC) begin
            if (is_load || is_move) begin
                case (dst)
                    3'd0:    reg_en[0] = 1'b1;
                    3'd1:    reg_en[1] = 1'b1;
                    3'd2:    reg_en[2] = 1'b1;
                    3'd3:    reg_en[3] = 1'b1;
                    3'd4:    reg_en[8] = 1'b1;
                    3'd5:    reg_en[5] = 1'b1;
                    3'd6:    reg_en[6] = 1'b1;
                    default: reg_en[7] = 1'b1;
                endcase
                if (is_load) begin
                    source_sel = SRC_PM_DATA;
                end else if (src == dst) begin
                    source_sel = SRC_I_PINS;
                end else begin
                    source_sel = {1'b0, src};
                end
                // Data-memory access post-increments i, unless i itself is the target
                if (((dst == 3'd7) || (is_move && (src == 3'd7))) && (dst != 3'd6)) begin
                    reg_en[6] = 1'b1;
                    i_sel     = 1'b1;
                end
            end else if (is_alu) begin
                reg_en[4] = 1'b1;
                x_sel     = ir[4];
                y_sel     = ir[3];
            end
        end
    end

    // Direct status outputs
    always_comb begin
        pm_address    = pc;
        ir_nibble     = ir[3:0];
        cu_sync_reset = (state == ST_RST);
    end

endmodule
